// File: rtl/bpf_pkg.sv
// Shared types for the packet bank scheduler: bank lifecycle states, length width, bank index.
package bpf_pkg;

  localparam int PACKET_BYTE_ADDR_WIDTH = 12;
  // One extra bit so a completely full 4096-byte bank has a representable length.
  localparam int LEN_WIDTH = PACKET_BYTE_ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    BANK_IDLE,
    BANK_WAIT_CPU,
    BANK_CPU,
    BANK_WAIT_FWD,
    BANK_FWD,
    BANK_DROP
  } bank_state_t;

  typedef logic bank_idx_t;

endpackage

// File: rtl/bank_slot.sv
// One packet bank: lifecycle state register and latched packet length, advanced by single-cycle events.
// State changes on the edge that samples an event; the caller guarantees at most one event per edge.
module bank_slot
  import bpf_pkg::*;
#(
  parameter int LW = LEN_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill,
  input  logic [LW-1:0] fill_len,
  input  logic          start,
  input  logic          verdict,
  input  logic          accept,
  input  logic          skip,
  input  logic          take,
  input  logic          freed,
  output bank_state_t   state,
  output logic [LW-1:0] len
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BANK_IDLE;
      len   <= '0;
    end else if (fill) begin
      state <= BANK_WAIT_CPU;
      len   <= fill_len;
    end else if (start) begin
      state <= BANK_CPU;
    end else if (verdict) begin
      state <= accept ? BANK_WAIT_FWD : BANK_DROP;
    end else if (take) begin
      state <= BANK_FWD;
    end else if (skip || freed) begin
      state <= BANK_IDLE;
    end
  end

endmodule

// File: rtl/packet_bank_sched.sv
// Ping-pong scheduler granting two packet banks to snooper, CPU and forwarder in arrival order.
// sn_done -> cpu_start is 2 cycles; sn_bank_vld low while both banks are busy is the snooper backpressure.
module packet_bank_sched #(
  parameter int PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int LEN_WIDTH              = PACKET_BYTE_ADDR_WIDTH + 1,
  parameter int CNT_WIDTH              = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 sn_bank_vld,
  output logic                 sn_bank,
  input  logic                 sn_done,
  input  logic [LEN_WIDTH-1:0] sn_len,
  output logic                 cpu_start,
  output logic                 cpu_bank,
  output logic [LEN_WIDTH-1:0] cpu_len,
  input  logic                 cpu_done,
  input  logic                 cpu_accept,
  output logic                 fwd_vld,
  output logic                 fwd_bank,
  output logic [LEN_WIDTH-1:0] fwd_len,
  input  logic                 fwd_done,
  output logic [CNT_WIDTH-1:0] acc_cnt,
  output logic [CNT_WIDTH-1:0] rej_cnt
);
  import bpf_pkg::*;

  bank_state_t          st [2];
  logic [LEN_WIDTH-1:0] ln [2];
  bank_idx_t            p_sn, p_cpu, p_fwd;

  logic fill_ev, start_ev, verdict_ev, skip_ev, take_ev, free_ev;

  // Each event is qualified by the state of the bank its own pointer selects,
  // so two agents can never act on the same bank in one cycle.
  assign fill_ev    = sn_done && (sn_len != '0) && (st[p_sn] == BANK_IDLE);
  assign start_ev   = (st[p_cpu] == BANK_WAIT_CPU);
  assign verdict_ev = cpu_done && (st[p_cpu] == BANK_CPU);
  assign skip_ev    = (st[p_fwd] == BANK_DROP);
  assign take_ev    = (st[p_fwd] == BANK_WAIT_FWD);
  assign free_ev    = fwd_done && (st[p_fwd] == BANK_FWD);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    bank_slot #(.LW(LEN_WIDTH)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .fill     (fill_ev    && (p_sn  == bank_idx_t'(b))),
      .fill_len (sn_len),
      .start    (start_ev   && (p_cpu == bank_idx_t'(b))),
      .verdict  (verdict_ev && (p_cpu == bank_idx_t'(b))),
      .accept   (cpu_accept),
      .skip     (skip_ev    && (p_fwd == bank_idx_t'(b))),
      .take     (take_ev    && (p_fwd == bank_idx_t'(b))),
      .freed    (free_ev    && (p_fwd == bank_idx_t'(b))),
      .state    (st[b]),
      .len      (ln[b])
    );
  end

  assign sn_bank     = p_sn;
  assign sn_bank_vld = (st[p_sn] == BANK_IDLE);
  assign cpu_bank    = p_cpu;
  assign cpu_len     = ln[p_cpu];
  assign fwd_bank    = p_fwd;
  assign fwd_len     = ln[p_fwd];
  assign fwd_vld     = (st[p_fwd] == BANK_FWD);

  always_ff @(posedge clk) begin
    if (rst) begin
      p_sn      <= 1'b0;
      p_cpu     <= 1'b0;
      p_fwd     <= 1'b0;
      cpu_start <= 1'b0;
      acc_cnt   <= '0;
      rej_cnt   <= '0;
    end else begin
      cpu_start <= start_ev;
      if (fill_ev)            p_sn  <= ~p_sn;
      if (verdict_ev)         p_cpu <= ~p_cpu;
      if (skip_ev || free_ev) p_fwd <= ~p_fwd;
      if (verdict_ev &&  cpu_accept) acc_cnt <= acc_cnt + CNT_WIDTH'(1);
      if (verdict_ev && !cpu_accept) rej_cnt <= rej_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
